// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and elaboration helpers for the PLL reset sequencer.
// The state encoding is visible on state_dbg, so the values are fixed.
package pll_reset_pkg;

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    // Wide enough to hold the largest threshold without wrapping.
    function automatic int timer_width(input int rst_pulse,
                                       input int lock_stable,
                                       input int lock_timeout,
                                       input int release_span);
        int largest;
        largest = rst_pulse;
        if (lock_stable > largest)  largest = lock_stable;
        if (lock_timeout > largest) largest = lock_timeout;
        if (release_span > largest) largest = release_span;
        return $clog2(largest) + 1;
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Two-flop synchronizer for a single level signal.
// Both flops clear on the synchronous reset.
module bit_synchronizer (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: flops are written with <= so every stage samples the pre-edge value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Owns the PLL reset, qualifies lock, and releases downstream stage resets in order.
// Runs on the free-running reference clock; all outputs come straight from flops.
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int NUM_STAGES          = 2,
    parameter int STAGE_GAP_CYCLES    = 8,
    parameter int CNT_W               = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_locked_async,
    input  logic                  soft_reset_req,
    output logic                  pll_rst,
    output logic [NUM_STAGES-1:0] stage_reset_n,
    output logic                  ready,
    output logic [1:0]            state_dbg,
    output logic [CNT_W-1:0]      retry_count,
    output logic [CNT_W-1:0]      loss_count
);

    localparam int TW = timer_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES,
                                    LOCK_TIMEOUT_CYCLES, NUM_STAGES * STAGE_GAP_CYCLES);

    // Each threshold is compared one cycle early so the registered result lands on time.
    localparam logic [TW-1:0]    RST_LAST     = TW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0]    STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

    seq_state_e            state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [TW-1:0]         stable_q, stable_d;
    logic [CNT_W-1:0]      retry_q, retry_d;
    logic [CNT_W-1:0]      loss_q, loss_d;
    logic                  pll_rst_q, pll_rst_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  ready_q, ready_d;
    logic [NUM_STAGES-1:0] release_mask;
    logic                  locked_s;

    bit_synchronizer u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked_async),
        .q       (locked_s)
    );

    // Bit i is due when the RELEASE timer is one short of (i+1) gaps.
    always_comb begin
        release_mask = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (timer_q == TW'((i + 1) * STAGE_GAP_CYCLES - 1)) begin
                release_mask[i] = 1'b1;
            end
        end
    end

    // NOTE: every variable gets a default before the case so no path infers a latch.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        stage_d = stage_q;

        case (state_q)
            PLL_RST: begin
                stage_d = '0;
                if (timer_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                stage_d = '0;
                if (locked_s && (stable_q == STABLE_LAST)) begin
                    state_d = RELEASE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = PLL_RST;
                    if (retry_q != CNT_MAX) retry_d = retry_q + 1'b1;
                end
            end
            RELEASE: begin
                if (!locked_s) begin
                    state_d = PLL_RST;
                    stage_d = '0;
                end else begin
                    stage_d = stage_q | release_mask;
                    if (release_mask[NUM_STAGES-1]) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = PLL_RST;
                    stage_d = '0;
                    if (loss_q != CNT_MAX) loss_d = loss_q + 1'b1;
                end else if (soft_reset_req) begin
                    state_d = RELEASE;
                    stage_d = '0;
                end else begin
                    stage_d = '1;
                end
            end
            default: begin
                state_d = PLL_RST;
                stage_d = '0;
            end
        endcase
    end

    // One timer serves every state; it restarts on each transition and idles in RUN.
    always_comb begin
        timer_d   = ((state_d != state_q) || (state_q == RUN)) ? '0 : timer_q + 1'b1;
        stable_d  = ((state_q == WAIT_LOCK) && (state_d == WAIT_LOCK) && locked_s)
                    ? stable_q + 1'b1 : '0;
        pll_rst_d = (state_d == PLL_RST);
        ready_d   = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= PLL_RST;
            timer_q   <= '0;
            stable_q  <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            stage_q   <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            stable_q  <= stable_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            stage_q   <= stage_d;
            ready_q   <= ready_d;
        end
    end

    assign pll_rst       = pll_rst_q;
    assign stage_reset_n = stage_q;
    assign ready         = ready_q;
    assign state_dbg     = state_q;
    assign retry_count   = retry_q;
    assign loss_count    = loss_q;

endmodule
